seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Sequential restoring divider; the inverse operation to the team's registered multiplier.
- Takes WIDTH-bit dividend `a` and divisor `b` on a start strobe.
- Produces quotient and remainder after WIDTH iterations, one quotient bit per clock.
- Sits beside the multiplier stage in the arithmetic datapath and uses the same start/result style.

Parameters:
- WIDTH, 4, operand width in bits; must be even and >= 2.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on posedge clk, honoured only when idle.
- a  input  WIDTH  dividend; captured on an accepted start.
- b  input  WIDTH  divisor; captured on an accepted start.
- q  output  WIDTH  quotient, registered; held until the next completion.
- r  output  WIDTH  remainder, registered; held until the next completion.
- busy  output  1  high while an iteration is in progress.
- done  output  1  one-cycle pulse; q, r and div0 are valid in this cycle.
- div0  output  1  set with done when the captured divisor was zero.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, counter=0; q=0, r=0, busy=0, done=0, div0=0.
  - Any operation in progress is abandoned; no done is produced for it.
- States: IDLE, RUN.
- IDLE with start=1 at edge E0 and b!=0:
  - Capture a into the quotient/dividend shift register; capture b; clear the partial remainder (WIDTH+1 bits); counter=WIDTH.
  - Go to RUN; busy=1 from E0.
- IDLE with start=1 at E0 and b==0:
  - Stay in IDLE.
  - At E0: q=all ones, r=a, div0=1, done=1 (latency 1 cycle).
- RUN, each edge:
  - Shift {rem, dq} left by 1.
  - Trial = rem - b, computed as WIDTH+1 bits.
  - If the trial is non-negative: rem=trial and quotient LSB=1. Otherwise: keep rem and set quotient LSB=0.
  - Decrement counter.
- RUN edge with counter==1 (edge E0+WIDTH):
  - Load q and r from the final step result; done=1, div0=0, busy=0; go to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH. Throughput: one division per WIDTH+1 cycles.
- start while busy: ignored; a and b are not re-sampled.
- start in the cycle where done=1: accepted (state is IDLE); done falls on that edge.
- done and div0 are cleared on every edge where no completion occurs. q and r are not cleared.
- Invariant for every b!=0: a == q*b + r and r < b (unsigned).
- Edge cases:
  - a < b: q=0, r=a.
  - b=1: q=a, r=0.
  - a=0: q=0, r=0, with full WIDTH latency.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined: a and b are two's complement.
  - Magnitudes are taken at capture and the same unsigned core is run.
  - Quotient is negated if sign(a)^sign(b); remainder takes the sign of a (truncation toward zero).
  - Sign fix-up is applied on the completing edge, so latency is unchanged.
  - Divide by zero gives q=all ones, r=a (raw), div0=1.
  - Most-negative / -1: q=most-negative, r=0, no flag.
- Undefined: purely unsigned; no sign logic is synthesised.

Decomposition:
- Package seq_div_pkg holds:
  - state enum (IDLE, RUN);
  - function computing CNT_W from WIDTH;
  - DIV0_Q constant (all ones) as a width-parameterised function.
- One natural sub-module, div_step:
  - Combinational single restoring iteration.
  - Inputs: rem, dq, divisor. Outputs: next rem, next dq.
  - Trial subtract built from the team's ripple-carry adder with an inverted divisor and carry-in 1.
- The top module holds the FSM, counter, operand registers and output registers.

Test Plan (WIDTH=4):
- a=13, b=4, start pulse -> busy for 4 cycles; done at cycle 5 with q=3, r=1, div0=0.
- a=15, b=1 -> q=15, r=0; then a=3, b=9 issued in the done cycle -> accepted; 5 cycles later q=0, r=3.
- a=7, b=0 -> done and div0 the cycle after start; q=15, r=7; busy never asserted.
- a=12, b=5 started; start held with a=1, b=1 for 3 cycles while busy -> ignored; result q=2, r=2.
- a=14, b=3 started; rst pulsed after 2 cycles -> q=0, r=0, busy=0, no done; a new start (9/2) afterwards gives q=4, r=1.
- SEQ_DIV_SIGNED_EN: a=-7 (4'b1001), b=2 -> q=4'b1101 (-3), r=4'b1111 (-1). Exhaustive 16x16 sweep checks a==q*b+r for b!=0.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// SEQ_DIV_SIGNED_EN selects the two's complement variant in the top module.
package seq_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_WIDTH = 64;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // All-ones quotient reported on divide-by-zero; callers slice the low width bits.
  function automatic logic [MAX_WIDTH-1:0] div0_q(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/seq_div_div_step.sv
// One combinational restoring-division iteration: shift {rem, dq} left, trial-subtract divisor.
// The trial subtract is a ripple-carry add of the inverted divisor with carry-in 1.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dq_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] dq_o
);

  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   nb;
  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] c;
  logic             ge;

  assign sh   = {rem_i[WIDTH-1:0], dq_i[WIDTH-1]};
  assign nb   = ~{1'b0, div_i};
  assign c[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_rca
    assign sum[i]   = sh[i] ^ nb[i] ^ c[i];
    assign c[i+1]   = (sh[i] & nb[i]) | (c[i] & (sh[i] ^ nb[i]));
  end

  // Carry out of the subtract means the shifted remainder was >= divisor.
  assign ge    = c[WIDTH+1];
  assign rem_o = ge ? sum : sh;
  assign dq_o  = {dq_i[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's complement operands (truncation toward zero).
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [MAX_WIDTH-1:0] DIV0_FULL = div0_q(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             div0_q_r, div0_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dq;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dq_i  (dq_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .dq_o  (step_dq)
  );

`ifdef SEQ_DIV_SIGNED_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;

  // Core runs on magnitudes; signs are re-applied on the completing edge.
  assign a_mag = a[WIDTH-1] ? ('0 - a) : a;
  assign b_mag = b[WIDTH-1] ? ('0 - b) : b;
  assign q_fix = q_neg_q ? ('0 - step_dq) : step_dq;
  assign r_fix = r_neg_q ? ('0 - step_rem[WIDTH-1:0]) : step_rem[WIDTH-1:0];

  always_comb begin
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (state_q == IDLE && start) begin
      q_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
      r_neg_d = a[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
  assign q_fix = step_dq;
  assign r_fix = step_rem[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    div_d   = div_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            q_d    = DIV0_FULL[WIDTH-1:0];
            r_d    = a;
            done_d = 1'b1;
            div0_d = 1'b1;
          end else begin
            dq_d    = a_mag;
            div_d   = b_mag;
            rem_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dq_d  = step_dq;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          q_d     = q_fix;
          r_d     = r_fix;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dq_q     <= '0;
      div_q    <= '0;
      q_q      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      div0_q_r <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dq_q     <= dq_d;
      div_q    <= div_d;
      q_q      <= q_d;
      r_q      <= r_d;
      done_q   <= done_d;
      div0_q_r <= div0_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign div0 = div0_q_r;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: arithmetic reference model, per-cycle compare, directed pins.
// Follows SEQ_DIV_SIGNED_EN to select signed or unsigned expectations.
module tb_seq_div;

  localparam int W = 4;

  logic         clk, rst, start;
  logic [W-1:0] a, b, q, r;
  logic         busy, done, div0;

  int tests_run = 0;
  int tests_failed = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic: what the quotient/remainder must be.
  task automatic ref_div(input logic [W-1:0] aa, input logic [W-1:0] bb,
                         output logic [W-1:0] eq, output logic [W-1:0] er);
`ifdef SEQ_DIV_SIGNED_EN
    int sa, sb;
    sa = int'($signed(aa));
    sb = int'($signed(bb));
    eq = W'(sa / sb);
    er = W'(sa % sb);
`else
    eq = aa / bb;
    er = aa % bb;
`endif
  endtask

  // Behavioural model: timing from the start/done rules, values from ref_div.
  int           m_left;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_done, m_div0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_q = '0; m_r = '0; m_done = 1'b0; m_div0 = 1'b0;
    end else begin
      m_done = 1'b0;
      m_div0 = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_q = p_q; m_r = p_r; m_done = 1'b1;
        end
      end else if (start) begin
        if (b == '0) begin
          m_q = '1; m_r = a; m_done = 1'b1; m_div0 = 1'b1;
        end else begin
          ref_div(a, b, p_q, p_r);
          m_left = W;
        end
      end
    end
  end

  // Scoreboard: every cycle, outputs against the model.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("div0", 32'(div0), 32'(m_div0));
    chk("q", 32'(q), 32'(m_q));
    chk("r", 32'(r), 32'(m_r));
  end

  // Driver: launch at a negedge; hold start (with junk operands) for 'hold' busy cycles.
  task automatic do_div(input logic [W-1:0] aa, input logic [W-1:0] bb, input int hold,
                        output int lat, output logic saw_busy);
    a = aa; b = bb; start = 1'b1;
    lat = 0;
    saw_busy = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) saw_busy = 1'b1;
      if (lat <= hold) begin
        a = 4'd1; b = 4'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < 40);
    start = 1'b0;
    if (!done) chk("timeout_done", 32'(done), 32'd1);
  endtask

  task automatic pin(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input int hold, input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic ed0, input int elat);
    int lat;
    logic sb;
    do_div(aa, bb, hold, lat, sb);
    chk({name, "_q"}, 32'(q), 32'(eq));
    chk({name, "_r"}, 32'(r), 32'(er));
    chk({name, "_div0"}, 32'(div0), 32'(ed0));
    chk({name, "_lat"}, 32'(lat), 32'(elat));
    if (elat == 1) chk({name, "_nobusy"}, 32'(sb), 32'd0);
  endtask

  initial begin
    int           lat;
    logic         sb;
    logic [W-1:0] lhs, eq, er;
    int           qi, bi, ri;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef SEQ_DIV_SIGNED_EN
    pin("p13_4", 4'd13, 4'd4, 0, 4'd0, 4'd13, 1'b0, 5);
    pin("p15_1", 4'd15, 4'd1, 0, 4'd15, 4'd0, 1'b0, 5);
    pin("p3_9", 4'd3, 4'd9, 0, 4'd0, 4'd3, 1'b0, 5);
    pin("p7_0", 4'd7, 4'd0, 0, 4'd15, 4'd7, 1'b1, 1);
    pin("p12_5h", 4'd12, 4'd5, 3, 4'd0, 4'd12, 1'b0, 5);
    pin("pm7_2", 4'b1001, 4'd2, 0, 4'b1101, 4'b1111, 1'b0, 5);
    pin("pm8_m1", 4'b1000, 4'b1111, 0, 4'b1000, 4'd0, 1'b0, 5);
`else
    pin("p13_4", 4'd13, 4'd4, 0, 4'd3, 4'd1, 1'b0, 5);
    pin("p15_1", 4'd15, 4'd1, 0, 4'd15, 4'd0, 1'b0, 5);
    pin("p3_9", 4'd3, 4'd9, 0, 4'd0, 4'd3, 1'b0, 5);
    pin("p7_0", 4'd7, 4'd0, 0, 4'd15, 4'd7, 1'b1, 1);
    pin("p12_5h", 4'd12, 4'd5, 3, 4'd2, 4'd2, 1'b0, 5);
    pin("p0_5", 4'd0, 4'd5, 0, 4'd0, 4'd0, 1'b0, 5);
`endif

    // Reset in the middle of an operation: no done afterwards.
    a = 4'd14; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_r", 32'(r), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
`ifdef SEQ_DIV_SIGNED_EN
    pin("p9_2", 4'd9, 4'd2, 0, 4'd13, 4'd15, 1'b0, 5);
`else
    pin("p9_2", 4'd9, 4'd2, 0, 4'd4, 4'd1, 1'b0, 5);
`endif

    // Exhaustive sweep: quotient/remainder identity for every non-zero divisor.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++) begin
        do_div(W'(ia), W'(ib), 0, lat, sb);
`ifdef SEQ_DIV_SIGNED_EN
        qi = int'($signed(q)); bi = ib - ((ib >= 8) ? 16 : 0); ri = int'($signed(r));
        lhs = W'(qi * bi + ri);
        chk("sweep_id", 32'(lhs), 32'(ia));
        chk("sweep_rlt", 32'((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi)), 32'd1);
`else
        qi = int'(q); bi = ib; ri = int'(r);
        chk("sweep_id", 32'(qi * bi + ri), 32'(ia));
        chk("sweep_rlt", 32'(ri < bi), 32'd1);
`endif
      end
    end

    // Random traffic: starts at any time, including while busy and in done cycles.
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 15));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Model self-pin: reference arithmetic on a known case.
    ref_div(4'd14, 4'd3, eq, er);
`ifdef SEQ_DIV_SIGNED_EN
    chk("model_q", 32'(eq), 32'd0);
    chk("model_r", 32'(er), 32'd14);
`else
    chk("model_q", 32'(eq), 32'd4);
    chk("model_r", 32'(er), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
